// File: rtl/la_capture_core.sv
// Embedded logic-analyser capture engine: circular sample buffer with a maskable trigger and a trigger-aligned read window.
// Latency: one sample is written per clock while capturing; the read port returns data one cycle after rd_en_i.
// Backpressure: none. Sampling is free-running and reads are accepted every cycle in any state.
module la_capture_core #(
  parameter int DATA_W = 16,
  parameter int TRIG_W = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [TRIG_W-1:0] trig_value_i,
  input  logic [TRIG_W-1:0] trig_edge_i,
  input  logic              trig_mode_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [2:0]        state_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] pretrig_q;
  logic [TRIG_W-1:0] mask_q, value_q, edge_q;
  logic              mode_q;
  logic [TRIG_W-1:0] trig_prev_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              we;
  logic              cfg_ld;

  logic [DATA_W-1:0] mem [DEPTH];

  // Per-channel hit against the configuration latched at arm time.
  logic [TRIG_W-1:0] lvl_hit, rise, fall, edge_hit, ch_hit;
  logic              trig_fire;
  logic [ADDR_W-1:0] rd_phys;

  assign lvl_hit  = ~(trig_i ^ value_q);
  assign rise     = trig_i & ~trig_prev_q;
  assign fall     = ~trig_i & trig_prev_q;
  assign edge_hit = (value_q & rise) | (~value_q & fall);
  assign ch_hit   = (edge_q & edge_hit) | (~edge_q & lvl_hit);
  // An empty mask fires unconditionally, regardless of AND/OR mode.
  assign trig_fire = (mask_q == '0) |
                     (mode_q ? |(ch_hit & mask_q) : &(ch_hit | ~mask_q));

  assign rd_phys = trig_addr_q + rd_addr_i;

  // Capture sequencing: decides the write enable and counter updates for this cycle.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    we          = 1'b0;
    cfg_ld      = 1'b0;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            // The acceptance cycle already writes the first pre-trigger sample.
            cfg_ld    = 1'b1;
            we        = 1'b1;
            pre_cnt_d = ONE;
            state_d   = (pretrig_i > ONE) ? S_PRE : S_WAIT;
          end
        end
        S_PRE: begin
          we        = 1'b1;
          pre_cnt_d = pre_cnt_q + ONE;
          if (pre_cnt_d == pretrig_q) state_d = S_WAIT;
        end
        S_WAIT: begin
          we = 1'b1;
          if (trig_fire) begin
            trig_addr_d = wp_q - pretrig_q;
            post_cnt_d  = ~pretrig_q;  // DEPTH-1-pretrig
            state_d     = (pretrig_q == '1) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (post_cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            we         = 1'b1;
            post_cnt_d = post_cnt_q - ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign wp_d = we ? (wp_q + ONE) : wp_q;

  // Control state, counters, latched trigger configuration and read-valid pipe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      pretrig_q   <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      edge_q      <= '0;
      mode_q      <= 1'b0;
      trig_prev_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      trig_prev_q <= trig_i;
      rd_valid_q  <= rd_en_i;
      if (cfg_ld) begin
        pretrig_q <= pretrig_i;
        mask_q    <= trig_mask_i;
        value_q   <= trig_value_i;
        edge_q    <= trig_edge_i;
        mode_q    <= trig_mode_i;
      end
    end
  end

  // Sample buffer write port; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we) mem[wp_q] <= data_i;
  end

  // Registered read port; a same-address write in this cycle returns the old word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_phys];
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign state_o     = state_q;
  assign done_o      = (state_q == S_DONE);
  assign trig_addr_o = trig_addr_q;

endmodule

// File: tb/tb_la_capture_core.sv
module tb_la_capture_core;
  localparam int DW = 16;
  localparam int TW = 4;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          arm;
  logic          abort;
  logic [AW-1:0] pretrig;
  logic [TW-1:0] trig_mask;
  logic [TW-1:0] trig_value;
  logic [TW-1:0] trig_edge;
  logic          trig_mode;
  logic [TW-1:0] trig;
  logic [DW-1:0] data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [2:0]    state;
  logic          done;
  logic [AW-1:0] trig_addr;

  logic [15:0] cyc = 16'd0;
  logic [15:0] a;
  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        dc;
    logic [3:0]  idx;
    logic [15:0] exp;
  } rd_exp_t;
  rd_exp_t sb[$];
  rd_exp_t mon_e;

  la_capture_core #(.DATA_W(DW), .TRIG_W(TW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .abort_i(abort),
    .pretrig_i(pretrig), .trig_mask_i(trig_mask), .trig_value_i(trig_value),
    .trig_edge_i(trig_edge), .trig_mode_i(trig_mode), .trig_i(trig),
    .data_i(data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .state_o(state),
    .done_o(done), .trig_addr_o(trig_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Probe data is a free-running cycle counter.
  always @(posedge clk) cyc <= cyc + 16'd1;
  assign data = cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read results are popped from the scoreboard as they appear.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        if (!mon_e.dc) chk($sformatf("rd_idx%0d", mon_e.idx), 32'(rd_data), 32'(mon_e.exp));
      end
    end
  end

  task automatic to_data(input logic [15:0] v);
    int n = 0;
    while (cyc != v && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != v) chk("to_data_timeout", 32'(cyc), 32'(v));
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 32'(done), 32'd1);
  endtask

  // Arm pulse; config inputs are scrambled afterwards since only the latched copy should matter.
  task automatic arm_cfg(input logic [3:0] p, input logic [3:0] m, input logic [3:0] v,
                         input logic [3:0] e, input logic md);
    pretrig = p; trig_mask = m; trig_value = v; trig_edge = e; trig_mode = md;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    pretrig = ~p; trig_mask = ~m; trig_value = ~v; trig_edge = ~e; trig_mode = ~md;
  endtask

  // Window logical i holds probe value t - p + i.
  task automatic read_window(input logic [15:0] t, input int p);
    for (int i = 0; i < 16; i++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(i);
      sb.push_back({1'b0, 4'(i), 16'(t - 16'(p) + 16'(i))});
      @(negedge clk);
    end
    rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; pretrig = '0; trig_mask = '0;
    trig_value = '0; trig_edge = '0; trig_mode = 1'b0; trig = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_trig_addr", 32'(trig_addr), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;

    // Level AND, pretrig 4, trigger at 0x0030.
    to_data(16'h0020);
    arm_cfg(4'd4, 4'b0011, 4'b0011, 4'b0000, 1'b0);
    to_data(16'h0030);
    trig = 4'b0011;
    @(negedge clk);
    trig = 4'b0000;
    wait_done(40);
    chk("t1_state_done", 32'(state), 32'd4);
    chk("t1_trig_addr", 32'(trig_addr), 32'd12);
    read_window(16'h0030, 4);

    // Rising edge OR, pretrig 0; held level and a falling edge must not fire.
    trig = 4'b0100;
    to_data(16'h00E0);
    arm_cfg(4'd0, 4'b0100, 4'b0100, 4'b0100, 1'b1);
    to_data(16'h00E8);
    chk("t2_level_no_trig", 32'(state), 32'd2);
    trig = 4'b0000;
    to_data(16'h00F8);
    chk("t2_fall_no_trig", 32'(state), 32'd2);
    to_data(16'h0100);
    trig = 4'b0100;
    @(negedge clk);
    wait_done(40);
    read_window(16'h0100, 0);
    trig = 4'b0000;

    // Pre-fill gating: condition true from arm, pretrig 8.
    trig = 4'b0001;
    a = cyc + 16'd4;
    to_data(a);
    arm_cfg(4'd8, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    to_data(a + 16'd16);
    chk("t3_done_not_yet", 32'(done), 32'd0);
    @(negedge clk);
    chk("t3_done_at_16", 32'(done), 32'd1);
    read_window(a + 16'd8, 8);

    // pretrig 15: DONE right after the trigger cycle.
    a = cyc + 16'd4;
    to_data(a);
    arm_cfg(4'd15, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    to_data(a + 16'd15);
    chk("t4_p15_wait", 32'(state), 32'd2);
    @(negedge clk);
    chk("t4_p15_done", 32'(state), 32'd4);
    read_window(a + 16'd15, 15);

    // Empty mask fires on the first WAIT cycle, even in OR mode.
    trig = 4'b0000;
    a = cyc + 16'd4;
    to_data(a);
    arm_cfg(4'd2, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    wait_done(40);
    read_window(a + 16'd2, 2);

    // Abort mid-POST, then a clean re-capture.
    a = cyc + 16'd4;
    to_data(a);
    arm_cfg(4'd4, 4'b0011, 4'b0011, 4'b0000, 1'b0);
    to_data(a + 16'd8);
    trig = 4'b0011;
    @(negedge clk);
    trig = 4'b0000;
    to_data(a + 16'd11);
    chk("t5_in_post", 32'(state), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort_state", 32'(state), 32'd0);
    chk("t5_abort_done", 32'(done), 32'd0);
    to_data(a + 16'd16);
    chk("t5_stay_idle", 32'(state), 32'd0);
    a = cyc + 16'd4;
    to_data(a);
    arm_cfg(4'd5, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    wait_done(40);
    read_window(a + 16'd5, 5);

    // Abort from DONE, then arm+abort together stays IDLE.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5b_abort_from_done", 32'(state), 32'd0);
    arm = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    abort = 1'b0;
    chk("t5b_arm_abort", 32'(state), 32'd0);
    @(negedge clk);
    chk("t5b_arm_abort_hold", 32'(state), 32'd0);

    // Arm during WAIT is ignored.
    a = cyc + 16'd4;
    to_data(a);
    arm_cfg(4'd4, 4'b0011, 4'b0011, 4'b0000, 1'b0);
    to_data(a + 16'd8);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk("t5c_arm_in_wait", 32'(state), 32'd2);
    to_data(a + 16'd12);
    trig = 4'b0011;
    @(negedge clk);
    trig = 4'b0000;
    wait_done(40);
    read_window(a + 16'd12, 4);

    // Asynchronous reset mid-POST, then read latency after release.
    a = cyc + 16'd4;
    to_data(a);
    arm_cfg(4'd4, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    to_data(a + 16'd8);
    chk("t6_in_post", 32'(state), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_rst_trig_addr", 32'(trig_addr), 32'd0);
    chk("t6_rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rd_valid_before", 32'(rd_valid), 32'd0);
    rd_en = 1'b1;
    rd_addr = 4'd3;
    sb.push_back({1'b1, 4'd3, 16'd0});
    @(negedge clk);
    rd_en = 1'b0;
    chk("t6_rd_valid_1cyc", 32'(rd_valid), 32'd1);
    @(negedge clk);
    chk("t6_rd_valid_after", 32'(rd_valid), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
